// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search driving an external magnitude comparator
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_s,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             error
);
  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, TEST} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] kbit, decided;
  logic legal;
  // current bit mask, trial with bit k resolved by the comparator, and one-hot flag check
  always_comb begin
    kbit = {{(WIDTH-1){1'b0}}, 1'b1} << k;
    decided = cmp_g ? trial : (trial & ~kbit);
    legal = ({cmp_g, cmp_e, cmp_s} == 3'b100) || ({cmp_g, cmp_e, cmp_s} == 3'b010) || ({cmp_g, cmp_e, cmp_s} == 3'b001);
  end
  // search state machine; all outputs registered, done defaults low so it pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          trial  <= {1'b1, {(WIDTH-1){1'b0}}};
          k      <= KW'(WIDTH-1);
          busy   <= 1'b1;
          found  <= 1'b0;
          error  <= 1'b0;
          result <= '0;
          state  <= TEST;
        end
      end else if (!legal) begin
        error  <= 1'b1;
        result <= '0;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else if (cmp_e) begin
        result <= trial;
        found  <= 1'b1;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else if (k == '0) begin
        result <= decided;
        found  <= 1'b0;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else begin
        trial <= decided | (kbit >> 1);
        k     <= k - KW'(1);
      end
    end
  end
endmodule
